// File: rtl/mrv1_ifetch_pkg.sv
// Shared types and helpers for the MRV1 instruction-fetch initiator.
package mrv1_ifetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_INCR_C = 32'd4;

  // Epoch increment that wraps at the tag width.
  function automatic logic [31:0] next_epoch(input logic [31:0] epoch,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (epoch + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/mrv1_ifetch_fifo.sv
// In-order response buffer for fetched {pc, instr} entries; flush clears all entries.
module mrv1_ifetch_fifo
  import mrv1_ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               data_i,
  input  logic                       pop_i,
  output fetch_entry_t               data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + AW'(1);
      if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
      count_o <= count_o + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wr_ptr] <= data_i;
  end

  assign data_o = mem[rd_ptr];

endmodule

// File: rtl/mrv1_ifetch.sv
// MRV1 instruction-fetch initiator: credit-limited tagged requests, epoch-based redirect.
// Optional macro MRV1_IFETCH_BYPASS_EN presents a response to decode in its arrival cycle.
module mrv1_ifetch
  import mrv1_ifetch_pkg::*;
#(
  parameter int unsigned IMEM_TAG_WIDTH_P = 2,
  parameter int unsigned FIFO_DEPTH_P     = 4,
  parameter logic [31:0] RESET_PC_P       = 32'h0000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  output logic                        imem_req_vld_o,
  input  logic                        imem_req_rdy_i,
  output logic [IMEM_TAG_WIDTH_P-1:0] imem_req_tag_o,
  output logic [31:0]                 imem_req_addr_o,
  input  logic                        imem_resp_vld_i,
  input  logic [31:0]                 imem_resp_data_i,
  input  logic [IMEM_TAG_WIDTH_P-1:0] imem_resp_tag_i,
  input  logic                        redirect_vld_i,
  input  logic [31:0]                 redirect_pc_i,
  output logic                        instr_vld_o,
  input  logic                        instr_rdy_i,
  output logic [31:0]                 instr_pc_o,
  output logic [31:0]                 instr_data_o
);

  localparam int unsigned TW = IMEM_TAG_WIDTH_P;
  localparam int unsigned CW = $clog2(FIFO_DEPTH_P) + 1;
  localparam int unsigned SW = $clog2((2 ** TW) * FIFO_DEPTH_P) + 1;
  localparam logic [TW-1:0] REDIR_MAX = '1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [TW-1:0] epoch;
  logic [TW-1:0] redir_cnt;
  logic [TW-1:0] redir_cnt_next;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occupancy;
  logic [SW-1:0] stale;
  logic [SW-1:0] stale_next;

  logic issue_fire, cur_resp, stale_resp, block, fifo_empty;
  logic bypass, push, pop;
  fetch_entry_t push_entry, head;

  assign target_pc  = redirect_pc_i & ~32'd3;
  assign occupancy  = inflight + fifo_count;
  assign block      = (stale != '0) && (redir_cnt == REDIR_MAX);
  assign fifo_empty = (fifo_count == '0);

  assign imem_req_vld_o  = rst_ni && (occupancy < CW'(FIFO_DEPTH_P)) && !block;
  assign imem_req_tag_o  = epoch;
  assign imem_req_addr_o = fetch_pc;
  assign issue_fire      = imem_req_vld_o && imem_req_rdy_i;

  assign cur_resp   = imem_resp_vld_i && (imem_resp_tag_i == epoch);
  assign stale_resp = imem_resp_vld_i && (imem_resp_tag_i != epoch) && (stale != '0);

`ifdef MRV1_IFETCH_BYPASS_EN
  assign bypass = cur_resp && fifo_empty && !redirect_vld_i;
`else
  assign bypass = 1'b0;
`endif

  assign instr_vld_o  = rst_ni && !redirect_vld_i && (!fifo_empty || bypass);
  assign instr_pc_o   = fifo_empty ? resp_pc : head.pc;
  assign instr_data_o = fifo_empty ? imem_resp_data_i : head.instr;

  assign pop        = instr_vld_o && instr_rdy_i && !fifo_empty;
  assign push       = cur_resp && !redirect_vld_i && !(bypass && instr_rdy_i);
  assign push_entry = '{pc: resp_pc, instr: imem_resp_data_i};

  // On redirect every current-epoch request still outstanding, including one
  // issued this cycle, turns stale; a response arriving now has already retired.
  always_comb begin
    stale_next    = stale - SW'(stale_resp);
    inflight_next = inflight + CW'(issue_fire) - CW'(cur_resp);
    if (redirect_vld_i) begin
      stale_next    = stale_next + SW'(inflight_next);
      inflight_next = '0;
    end
    redir_cnt_next = redir_cnt;
    if (stale_next == '0) begin
      redir_cnt_next = '0;
    end else if (redirect_vld_i && (redir_cnt != REDIR_MAX)) begin
      redir_cnt_next = redir_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc  <= RESET_PC_P;
      resp_pc   <= RESET_PC_P;
      epoch     <= '0;
      inflight  <= '0;
      stale     <= '0;
      redir_cnt <= '0;
    end else begin
      inflight  <= inflight_next;
      stale     <= stale_next;
      redir_cnt <= redir_cnt_next;
      if (redirect_vld_i) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        epoch    <= TW'(next_epoch(32'(epoch), TW));
      end else begin
        if (issue_fire) fetch_pc <= fetch_pc + PC_INCR_C;
        if (cur_resp)   resp_pc  <= resp_pc + PC_INCR_C;
      end
    end
  end

  mrv1_ifetch_fifo #(
    .DEPTH(FIFO_DEPTH_P)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_vld_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_mrv1_ifetch.sv
// Self-checking bench for mrv1_ifetch: in-order responder model, epoch/credit reference model.
module tb_mrv1_ifetch;

  localparam int unsigned W   = 2;
  localparam int unsigned D   = 4;
  localparam logic [31:0] RPC = 32'h100;
`ifdef MRV1_IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_vld, req_rdy;
  logic [W-1:0] req_tag;
  logic [31:0]  req_addr;
  logic         resp_vld;
  logic [31:0]  resp_data;
  logic [W-1:0] resp_tag;
  logic         redirect_vld;
  logic [31:0]  redirect_pc;
  logic         instr_vld, instr_rdy;
  logic [31:0]  instr_pc, instr_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned ep;
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        rq[$];
  logic [31:0] buf_q[$];
  int unsigned epoch_m, rc_m, cyc, last_due, lat_lo, lat_hi;
  logic [31:0] next_pc_m;

  always #5 clk = ~clk;

  mrv1_ifetch #(
    .IMEM_TAG_WIDTH_P(W),
    .FIFO_DEPTH_P    (D),
    .RESET_PC_P      (RPC)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .imem_req_vld_o  (req_vld),
    .imem_req_rdy_i  (req_rdy),
    .imem_req_tag_o  (req_tag),
    .imem_req_addr_o (req_addr),
    .imem_resp_vld_i (resp_vld),
    .imem_resp_data_i(resp_data),
    .imem_resp_tag_i (resp_tag),
    .redirect_vld_i  (redirect_vld),
    .redirect_pc_i   (redirect_pc),
    .instr_vld_o     (instr_vld),
    .instr_rdy_i     (instr_rdy),
    .instr_pc_o      (instr_pc),
    .instr_data_o    (instr_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int unsigned stale_count();
    int unsigned n = 0;
    foreach (rq[i]) if (rq[i].ep != epoch_m) n++;
    return n;
  endfunction

  task automatic model_reset();
    rq.delete();
    buf_q.delete();
    epoch_m   = 0;
    rc_m      = 0;
    next_pc_m = RPC;
    last_due  = cyc;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy);
    logic        resp_now, resp_cur, exp_req, exp_vld, consumed;
    logic [31:0] exp_pc;
    int unsigned cur_out, due;
    req_t        r;
    r = '{ep: 0, addr: 32'h0, due: 0};
    resp_now = (rq.size() != 0) && (rq[0].due <= cyc);
    if (resp_now) begin
      r         = rq[0];
      resp_vld  = 1'b1;
      resp_tag  = W'(r.ep);
      resp_data = r.addr;
    end else begin
      resp_vld  = 1'b0;
      resp_tag  = W'($urandom);
      resp_data = $urandom;
    end
    redirect_vld = redir;
    redirect_pc  = tgt;
    instr_rdy    = rdy;
    #1;
    cur_out = rq.size() - stale_count();
    exp_req = ((cur_out + buf_q.size()) < D) && !((stale_count() != 0) && (rc_m >= (1 << W) - 1));
    chk("req_vld", 32'(req_vld), 32'(exp_req));
    if (req_vld) begin
      chk("req_addr", req_addr, next_pc_m);
      chk("req_tag", 32'(req_tag), 32'(W'(epoch_m)));
    end
    resp_cur = resp_now && (r.ep == epoch_m);
    exp_vld  = !redir && ((buf_q.size() != 0) || (BYP && resp_cur));
    exp_pc   = (buf_q.size() != 0) ? buf_q[0] : r.addr;
    chk("instr_vld", 32'(instr_vld), 32'(exp_vld));
    if (exp_vld && instr_vld) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_data", instr_data, exp_pc);
    end
    consumed = 1'b0;
    if (resp_now) void'(rq.pop_front());
    if (req_vld && req_rdy) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      rq.push_back('{ep: epoch_m, addr: req_addr, due: due});
      last_due  = due;
      next_pc_m = next_pc_m + 32'd4;
    end
    if (exp_vld && rdy) begin
      if (buf_q.size() != 0) void'(buf_q.pop_front());
      else consumed = 1'b1;
    end
    if (redir) begin
      buf_q.delete();
      epoch_m++;
      next_pc_m = tgt & ~32'd3;
      rc_m++;
    end else if (resp_cur && !consumed) begin
      buf_q.push_back(r.addr);
    end
    if (stale_count() == 0) rc_m = 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_pulse(input int unsigned n);
    rst_n        = 1'b0;
    resp_vld     = 1'b0;
    redirect_vld = 1'b0;
    #1;
    chk("rst_req_vld", 32'(req_vld), 32'd0);
    chk("rst_instr_vld", 32'(instr_vld), 32'd0);
    repeat (n) begin
      @(negedge clk);
      #1;
      chk("rst_req_vld", 32'(req_vld), 32'd0);
      chk("rst_instr_vld", 32'(instr_vld), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; req_rdy = 1'b1; resp_vld = 1'b0; resp_data = '0; resp_tag = '0;
    redirect_vld = 1'b0; redirect_pc = '0; instr_rdy = 1'b1;
    cyc = 0; lat_lo = 1; lat_hi = 1;
    model_reset();
    @(negedge clk);
    reset_pulse(3);

    // Streaming with a ready decoder, then stalled decoder fills credits.
    repeat (20) step(1'b0, $urandom, 1'b1);
    repeat (12) step(1'b0, $urandom, 1'b0);
    repeat (12) step(1'b0, $urandom, 1'b1);

    // Redirect with requests in flight; response, issue and redirect coincide.
    lat_lo = 3; lat_hi = 3;
    repeat (10) step(1'b0, $urandom, 1'b1);
    step(1'b1, 32'h2000, 1'b1);
    repeat (20) step(1'b0, $urandom, 1'b1);

    // Slow responder with three back-to-back redirects exercises the aliasing block.
    lat_lo = 8; lat_hi = 8;
    repeat (12) step(1'b0, $urandom, 1'b1);
    step(1'b1, 32'h3000, 1'b1);
    step(1'b1, 32'h4001, 1'b1);
    step(1'b1, 32'h5002, 1'b1);
    repeat (40) step(1'b0, $urandom, 1'b1);

    // Random traffic; redirects withheld once the epoch window is exhausted.
    lat_lo = 1; lat_hi = 6;
    repeat (3000) begin
      logic redir;
      redir = ($urandom_range(15, 0) == 0) && (rc_m < (1 << W) - 1);
      step(redir, $urandom, $urandom_range(3, 0) != 0);
    end

    // Reset mid-stream, then restart from the reset PC.
    reset_pulse(2);
    lat_lo = 1; lat_hi = 1;
    repeat (30) step(1'b0, $urandom, 1'b1);
    lat_lo = 1; lat_hi = 4;
    repeat (500) begin
      logic redir;
      redir = ($urandom_range(20, 0) == 0) && (rc_m < (1 << W) - 1);
      step(redir, $urandom, $urandom_range(1, 0) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
